// File: rtl/final_layer_streaming.sv
// rtl/final_layer_streaming.sv - streaming XNOR-popcount output layer with sequential argmax
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 begin a new image (honoured in IDLE only)
//   in_valid/in_ready     beat handshake for data_in and weights_in
//   data_in               activation chunk, bit0 = lowest input index
//   weights_in            class c weights at [c*CHUNK_BITS +: CHUNK_BITS]
//   out_valid/out_ready   result handshake for answer and score
//   answer, score         winning class index and its popcount
//   busy                  high whenever the block is not IDLE
module final_layer_streaming #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK_BITS  = 28,
  localparam int SW = $clog2(NUM_INPUTS + 1),
  localparam int IW = $clog2(NUM_CLASSES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHUNK_BITS-1:0]             data_in,
  input  logic [NUM_CLASSES*CHUNK_BITS-1:0] weights_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IW-1:0]                     answer,
  output logic [SW-1:0]                     score,
  output logic                              busy
);

  localparam int NUM_BEATS = (NUM_INPUTS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LAST_BITS = NUM_INPUTS - (NUM_BEATS - 1) * CHUNK_BITS;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [IW-1:0] LAST_CLS  = IW'(NUM_CLASSES - 1);
  // Only the low LAST_BITS of the final beat are real inputs.
  localparam logic [CHUNK_BITS-1:0] LAST_MASK = {CHUNK_BITS{1'b1}} >> (CHUNK_BITS - LAST_BITS);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   scores [NUM_CLASSES];
  logic [SW-1:0]   addend [NUM_CLASSES];
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   cls_idx;
  logic [IW-1:0]   best_idx;
  logic [SW-1:0]   best_score;
  logic [CHUNK_BITS-1:0] mask;
  logic            beat_fire;
  logic            last_fire;
  logic [IW-1:0]   base_idx, new_idx;
  logic [SW-1:0]   base_score, new_score;

  function automatic logic [SW-1:0] popcnt(input logic [CHUNK_BITS-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK_BITS; i++) n = n + SW'(v[i]);
    return n;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign beat_fire = in_valid && in_ready;
  assign last_fire = beat_fire && (beat_cnt == LAST_BEAT);

  always_comb begin
    mask = (beat_cnt == LAST_BEAT) ? LAST_MASK : {CHUNK_BITS{1'b1}};
    for (int c = 0; c < NUM_CLASSES; c++)
      addend[c] = popcnt(~(data_in ^ weights_in[c*CHUNK_BITS +: CHUNK_BITS]) & mask);
  end

  // The first argmax step compares against class 0 directly, so the running
  // best never needs seeding while the scores are still being written.
  always_comb begin
    base_idx   = (cls_idx == IW'(1)) ? '0 : best_idx;
    base_score = (cls_idx == IW'(1)) ? scores[0] : best_score;
    if (scores[cls_idx] > base_score) begin
      new_idx   = cls_idx;
      new_score = scores[cls_idx];
    end else begin
      new_idx   = base_idx;
      new_score = base_score;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_fire) state_next = ARGMAX;
      ARGMAX:  if (cls_idx == LAST_CLS) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CLASSES; c++) scores[c] <= '0;
      beat_cnt   <= '0;
      cls_idx    <= '0;
      best_idx   <= '0;
      best_score <= '0;
      answer     <= '0;
      score      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < NUM_CLASSES; c++) scores[c] <= '0;
            beat_cnt <= '0;
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            for (int c = 0; c < NUM_CLASSES; c++) scores[c] <= scores[c] + addend[c];
            beat_cnt <= beat_cnt + BW'(1);
            if (last_fire) cls_idx <= IW'(1);
          end
        end
        ARGMAX: begin
          best_idx   <= new_idx;
          best_score <= new_score;
          cls_idx    <= cls_idx + IW'(1);
          // Published result changes only when a full argmax completes.
          if (cls_idx == LAST_CLS) begin
            answer <= new_idx;
            score  <= new_score;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_final_layer_streaming.sv
// tb/tb_final_layer_streaming.sv - scoreboard bench for final_layer_streaming
module tb_final_layer_streaming;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [27:0]  data0;
  logic [279:0] w0;
  logic [3:0]   answer0;
  logic [7:0]   score0;

  logic         start1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0]  data1;
  logic [319:0] w1;
  logic [3:0]   answer1;
  logic [7:0]   score1;

  final_layer_streaming u_dut28 (
    .clock(clock), .reset(reset), .start(start0), .in_valid(in_valid0), .in_ready(in_ready0),
    .data_in(data0), .weights_in(w0), .out_valid(out_valid0), .out_ready(out_ready0),
    .answer(answer0), .score(score0), .busy(busy0));

  final_layer_streaming #(.NUM_INPUTS(196), .NUM_CLASSES(10), .CHUNK_BITS(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_in(data1), .weights_in(w1), .out_valid(out_valid1), .out_ready(out_ready1),
    .answer(answer1), .score(score1), .busy(busy1));

  int total = 0;
  int bad = 0;
  int exp_a0[$], exp_s0[$], exp_a1[$], exp_s1[$];

  logic [195:0] act;
  logic [195:0] wt [10];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic [195:0] ones_low(input int n);
    logic [195:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Scoreboard monitors: pop whenever a result handshake is about to occur.
  always @(negedge clock) begin
    int ea, es;
    if (!reset && out_valid0 && out_ready0) begin
      if (exp_a0.size() == 0) chk("dut28 unexpected result", 1, 0);
      else begin
        ea = exp_a0.pop_front();
        es = exp_s0.pop_front();
        chk("dut28 answer", answer0, ea);
        chk("dut28 score", score0, es);
      end
    end
  end

  always @(negedge clock) begin
    int ea, es;
    if (!reset && out_valid1 && out_ready1) begin
      if (exp_a1.size() == 0) chk("dut32 unexpected result", 1, 0);
      else begin
        ea = exp_a1.pop_front();
        es = exp_s1.pop_front();
        chk("dut32 answer", answer1, ea);
        chk("dut32 score", score1, es);
      end
    end
  end

  task automatic push_exp(input int sel, input int a, input int s);
    if (sel == 0) begin exp_a0.push_back(a); exp_s0.push_back(s); end
    else          begin exp_a1.push_back(a); exp_s1.push_back(s); end
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Drives beat b and returns just after the edge that transferred it.
  task automatic drive_beat(input int sel, input int b);
    int n;
    logic r;
    int idx;
    if (sel == 0) begin
      data0 = act[b*28 +: 28];
      for (int c = 0; c < 10; c++) w0[c*28 +: 28] = wt[c][b*28 +: 28];
      in_valid0 = 1'b1;
    end else begin
      for (int i = 0; i < 32; i++) begin
        idx = b * 32 + i;
        data1[i] = (idx < 196) ? act[idx] : 1'b1;
        for (int c = 0; c < 10; c++) w1[c*32 + i] = (idx < 196) ? wt[c][idx] : 1'b1;
      end
      in_valid1 = 1'b1;
    end
    n = 0;
    forever begin
      @(negedge clock);
      r = (sel == 0) ? in_ready0 : in_ready1;
      @(posedge clock); #1;
      n++;
      if (r) break;
      if (n > 50) begin chk("beat accept timeout", 0, 1); break; end
    end
  endtask

  task automatic drop_valid();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic run_image(input int sel, input int stall_beat, input int ea, input int es,
                           input bit check_latency);
    int k;
    push_exp(sel, ea, es);
    pulse_start(sel);
    for (int b = 0; b < 7; b++) begin
      if (b == stall_beat) begin
        drop_valid();
        repeat (5) begin @(posedge clock); #1; end
      end
      drive_beat(sel, b);
    end
    drop_valid();
    if (check_latency) begin
      k = 0;
      while (!out_valid0 && k < 30) begin @(posedge clock); #1; k++; end
      chk("latency last beat to out_valid", k, 9);
    end
  endtask

  task automatic wait_out_valid(input int sel);
    int k;
    k = 0;
    while (((sel == 0) ? out_valid0 : out_valid1) == 1'b0 && k < 60) begin
      @(posedge clock); #1; k++;
    end
    chk("out_valid arrives", (sel == 0) ? out_valid0 : out_valid1, 1);
  endtask

  task automatic wait_idle(input int sel);
    int k;
    k = 0;
    while (((sel == 0) ? busy0 : busy1) == 1'b1 && k < 60) begin
      @(posedge clock); #1; k++;
    end
    chk("returns to idle", (sel == 0) ? busy0 : busy1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, in_ready0, 0);
    chk({tag, " out_valid"}, out_valid0, 0);
    chk({tag, " busy"}, busy0, 0);
    chk({tag, " answer"}, answer0, 0);
    chk({tag, " score"}, score0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int z[10];
    reset = 1'b1;
    start0 = 0; in_valid0 = 0; out_ready0 = 1; data0 = '0; w0 = '0;
    start1 = 0; in_valid1 = 0; out_ready1 = 1; data1 = '0; w1 = '0;
    act = '0;
    for (int c = 0; c < 10; c++) wt[c] = '0;

    @(negedge clock);
    check_reset_outputs("reset");
    chk("reset dut32 busy", busy1, 0);
    chk("reset dut32 out_valid", out_valid1, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1) only class 7 matches every bit
    act = '1;
    for (int c = 0; c < 10; c++) wt[c] = '0;
    wt[7] = '1;
    run_image(0, -1, 7, 196, 1'b1);
    wait_idle(0);

    // 2) tie between classes 3 and 5 at 150 resolves to 3
    act = '1;
    for (int c = 0; c < 10; c++) wt[c] = ones_low(c * 10);
    wt[3] = ones_low(150);
    wt[5] = ones_low(150) << 46;
    run_image(0, -1, 3, 150, 1'b0);
    wait_idle(0);

    // 3) 32-bit chunks: upper 28 bits of beat 6 are all-match garbage
    act = '1;
    for (int c = 0; c < 10; c++) wt[c] = '0;
    wt[2] = '1;
    run_image(1, -1, 2, 196, 1'b0);
    wait_idle(1);

    // 4) input stall before beat 3 and output backpressure for 10 cycles
    for (int i = 0; i < 196; i++) act[i] = i[0];
    for (int c = 0; c < 10; c++) wt[c] = act ^ ones_low(((c > 6) ? c - 6 : 6 - c) * 12 + 20);
    out_ready0 = 1'b0;
    run_image(0, 3, 6, 176, 1'b0);
    wait_out_valid(0);
    repeat (10) begin
      @(negedge clock);
      chk("held out_valid", out_valid0, 1);
      chk("held answer", answer0, 6);
      chk("held score", score0, 176);
    end
    @(posedge clock); #1;
    out_ready0 = 1'b1;
    wait_idle(0);

    // 5) reset after 3 beats, then a fresh image
    act = '1;
    for (int c = 0; c < 10; c++) wt[c] = '0;
    wt[7] = '1;
    pulse_start(0);
    for (int b = 0; b < 3; b++) drive_beat(0, b);
    drop_valid();
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid-image reset");
    @(posedge clock); #1;
    reset = 1'b0;
    z = '{5, 60, 12, 99, 33, 0, 98, 7, 50, 20};
    act = '0;
    for (int c = 0; c < 10; c++) wt[c] = ~ones_low(z[c]);
    run_image(0, -1, 3, 99, 1'b0);
    wait_idle(0);

    // 6) start during ACCUM and DONE is ignored; back-to-back second image
    act = '1;
    for (int c = 0; c < 9; c++) wt[c] = ones_low((c + 1) * 10);
    wt[9] = ones_low(195);
    out_ready0 = 1'b0;
    push_exp(0, 9, 195);
    pulse_start(0);
    drive_beat(0, 0);
    start0 = 1'b1;
    drive_beat(0, 1);
    start0 = 1'b0;
    for (int b = 2; b < 7; b++) drive_beat(0, b);
    drop_valid();
    wait_out_valid(0);
    pulse_start(0);
    @(negedge clock);
    chk("start in DONE: out_valid", out_valid0, 1);
    chk("start in DONE: busy", busy0, 1);
    chk("start in DONE: answer", answer0, 9);
    @(posedge clock); #1;
    act = '1;
    for (int c = 0; c < 10; c++) wt[c] = '0;
    out_ready0 = 1'b1;
    @(posedge clock); #1;
    run_image(0, -1, 0, 0, 1'b0);
    wait_idle(0);

    repeat (3) @(posedge clock);
    chk("dut28 scoreboard drained", exp_a0.size(), 0);
    chk("dut32 scoreboard drained", exp_a1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
